// File: rtl/s3g_uart_pkg.sv
// Shared constants, state encodings and the CRC-8 helper for the S3G bridge.
package s3g_uart_pkg;
  localparam logic [7:0] SYNC      = 8'hD5;
  localparam logic [7:0] MAX_LEN   = 8'd32;
  localparam logic [7:0] RSP_OK    = 8'h81;
  localparam logic [7:0] RSP_CRC   = 8'h83;
  localparam logic [7:0] RSP_CMD   = 8'h85;
  localparam logic [7:0] CMD_VER   = 8'h00;
  localparam logic [7:0] CMD_WR    = 8'h3C;
  localparam logic [7:0] CMD_RD    = 8'h3D;
  localparam logic [7:0] VER0      = 8'hBA;
  localparam logic [7:0] VER1      = 8'hCE;
  localparam logic [7:0] CRC_POLY  = 8'h8C;
  localparam logic [7:0] LOOP_ADDR = 8'd63;
  localparam int         TIMEOUT   = 100_000;

  typedef enum logic [2:0] {P_IDLE, P_LEN, P_PAY, P_CRC, P_EXEC} pkt_state_e;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;
  typedef enum logic       {T_IDLE, T_SHIFT} tx_state_e;

  // Dallas/Maxim CRC-8, one byte, LSB first.
  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r[0] ^ d[i]) ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    return r;
  endfunction
endpackage

// File: rtl/s3g_uart_phy.sv
// DDS 16x baud enable plus 8N1 UART receiver and transmitter.
module s3g_uart_phy
  import s3g_uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_en_i,
  input  logic       rx_i,
  output logic [7:0] rx_data_o,
  output logic       rx_done_o,
  input  logic       tx_wr_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_o,
  output logic       tx_done_o
);
  localparam longint unsigned INC64 =
    ((64'(BAUD) * 64'd16 << 32) + 64'(CLK_FREQ) / 2) / 64'(CLK_FREQ);
  localparam logic [31:0] INC = INC64[31:0];

  logic [31:0] acc_q;
  logic [32:0] sum;
  logic        tick_q;
  logic [1:0]  rx_s_q;
  logic        rx;
  rx_state_e   rs_q, rs_d;
  logic [3:0]  rcnt_q, rcnt_d;
  logic [2:0]  rbit_q, rbit_d;
  logic [7:0]  rsh_q, rsh_d;
  logic        rdone_q, rdone_d;
  tx_state_e   ts_q, ts_d;
  logic [3:0]  tcnt_q, tcnt_d, tbit_q, tbit_d;
  logic [9:0]  tsh_q, tsh_d;
  logic        tdone_q, tdone_d;

  assign sum       = {1'b0, acc_q} + {1'b0, INC};
  assign rx        = rx_s_q[1];
  assign rx_data_o = rsh_q;
  assign rx_done_o = rdone_q;
  assign tx_o      = tsh_q[0];
  assign tx_done_o = tdone_q;

  // Phase accumulator, input synchronizer and FSM state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0; tick_q <= 1'b0; rx_s_q <= 2'b11;
      rs_q <= R_IDLE; rcnt_q <= '0; rbit_q <= '0; rsh_q <= '0; rdone_q <= 1'b0;
      ts_q <= T_IDLE; tcnt_q <= '0; tbit_q <= '0; tsh_q <= '1; tdone_q <= 1'b0;
    end else begin
      acc_q <= sum[31:0]; tick_q <= sum[32]; rx_s_q <= {rx_s_q[0], rx_i};
      rs_q <= rs_d; rcnt_q <= rcnt_d; rbit_q <= rbit_d; rsh_q <= rsh_d; rdone_q <= rdone_d;
      ts_q <= ts_d; tcnt_q <= tcnt_d; tbit_q <= tbit_d; tsh_q <= tsh_d; tdone_q <= tdone_d;
    end
  end

  // Receiver: validate start at mid-bit, then sample every 16 ticks.
  always_comb begin
    rs_d = rs_q; rcnt_d = rcnt_q; rbit_d = rbit_q; rsh_d = rsh_q; rdone_d = 1'b0;
    case (rs_q)
      R_IDLE: if (!rx) begin rs_d = R_START; rcnt_d = '0; end
      R_START: if (tick_q) begin
        if (rcnt_q == 4'd7) begin
          rs_d = rx ? R_IDLE : R_DATA; rcnt_d = '0; rbit_d = '0;
        end else rcnt_d = rcnt_q + 4'd1;
      end
      R_DATA: if (tick_q) begin
        if (rcnt_q == 4'd15) begin
          rcnt_d = '0; rsh_d = {rx, rsh_q[7:1]}; rbit_d = rbit_q + 3'd1;
          if (rbit_q == 3'd7) rs_d = R_STOP;
        end else rcnt_d = rcnt_q + 4'd1;
      end
      R_STOP: if (tick_q) begin
        if (rcnt_q == 4'd15) begin rs_d = R_IDLE; rdone_d = rx; end
        else rcnt_d = rcnt_q + 4'd1;
      end
      default: rs_d = R_IDLE;
    endcase
    if (!rx_en_i) begin rs_d = R_IDLE; rdone_d = 1'b0; end
  end

  // Transmitter: start, 8 data bits, stop; done after the full stop bit.
  always_comb begin
    ts_d = ts_q; tcnt_d = tcnt_q; tbit_d = tbit_q; tsh_d = tsh_q; tdone_d = 1'b0;
    case (ts_q)
      T_IDLE: if (tx_wr_i) begin
        tsh_d = {1'b1, tx_data_i, 1'b0}; tcnt_d = '0; tbit_d = '0; ts_d = T_SHIFT;
      end
      T_SHIFT: if (tick_q) begin
        if (tcnt_q == 4'd15) begin
          tcnt_d = '0; tsh_d = {1'b1, tsh_q[9:1]};
          if (tbit_q == 4'd9) begin ts_d = T_IDLE; tdone_d = 1'b1; end
          else tbit_d = tbit_q + 4'd1;
        end else tcnt_d = tcnt_q + 4'd1;
      end
      default: ts_d = T_IDLE;
    endcase
  end
endmodule

// File: rtl/s3g_uart_top.sv
// AVR serial link to register-file bridge using S3G framed packets.
module s3g_uart_top
  import s3g_uart_pkg::*;
#(
  parameter int CLK_FREQ          = 50_000_000,
  parameter int AVR_BAUD_RATE     = 115200,
  parameter int EXT_BAUD_RATE     = 115200,
  parameter int CCLK_READY_CYCLES = 512
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cclk,
  input  logic       avr_tx,
  output logic       avr_rx,
  output logic [7:0] led
);
  localparam int CW = $clog2(CCLK_READY_CYCLES + 1);

  if (EXT_BAUD_RATE < 0) begin : g_ext_unused
  end

  logic [CW-1:0]    cc_q;
  logic             ready;
  logic [7:0]       rx_data;
  logic             rx_done, tx_line, tx_done;
  pkt_state_e       ps_q, ps_d;
  logic [16:0]      tmo_q;
  logic [7:0]       len_q, idx_q, crc_q;
  logic             crc_ok_q;
  logic [5:0][7:0]  pay_q;
  logic [31:0]      reg0_q, loop_q, rd_data;
  logic [4:0][7:0]  rp;
  logic [2:0]       rp_n;
  logic             wr_en, exec;
  logic [7:0][7:0]  fr_d, txb_q;
  logic [3:0]       fr_n, tlen_q;
  logic [2:0]       tidx_q;
  logic             txa_q, tx_wr_q;
  logic [7:0]       tx_byte_q, c;

  assign ready  = (cc_q == CW'(CCLK_READY_CYCLES));
  assign avr_rx = ready ? tx_line : 1'b1;
  assign led    = reg0_q[7:0];
  assign exec   = (ps_q == P_EXEC) && !txa_q;

  s3g_uart_phy #(.CLK_FREQ(CLK_FREQ), .BAUD(AVR_BAUD_RATE)) u_phy (
    .clk(clk), .rst_n(rst_n), .rx_en_i(ready), .rx_i(avr_tx),
    .rx_data_o(rx_data), .rx_done_o(rx_done),
    .tx_wr_i(tx_wr_q), .tx_data_i(tx_byte_q), .tx_o(tx_line), .tx_done_o(tx_done)
  );

  // Count consecutive cclk-high cycles; saturate at the ready threshold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     cc_q <= '0;
    else if (!cclk) cc_q <= '0;
    else if (!ready) cc_q <= cc_q + CW'(1);
  end

  // Packet receive next-state, including inter-byte timeout.
  always_comb begin
    ps_d = ps_q;
    case (ps_q)
      P_IDLE: if (rx_done && rx_data == SYNC) ps_d = P_LEN;
      P_LEN:  if (rx_done) ps_d = (rx_data == 8'd0 || rx_data > MAX_LEN) ? P_IDLE : P_PAY;
      P_PAY:  if (rx_done && idx_q == len_q - 8'd1) ps_d = P_CRC;
      P_CRC:  if (rx_done) ps_d = P_EXEC;
      P_EXEC: ps_d = P_IDLE;
      default: ps_d = P_IDLE;
    endcase
    if (ps_q != P_IDLE && ps_q != P_EXEC && !rx_done && tmo_q == 17'(TIMEOUT - 1))
      ps_d = P_IDLE;
  end

  // Decode the stored packet and assemble the response frame.
  always_comb begin
    rp = '0; rp_n = 3'd1; wr_en = 1'b0; fr_d = '0;
    rd_data = (pay_q[1] == LOOP_ADDR) ? loop_q : 32'd0;
    rp[0] = RSP_CMD;
    if (!crc_ok_q) rp[0] = RSP_CRC;
    else if (pay_q[0] == CMD_VER) begin
      rp[0] = RSP_OK; rp[1] = VER0; rp[2] = VER1; rp_n = 3'd3;
    end else if (pay_q[0] == CMD_WR && len_q == 8'd6) begin
      rp[0] = RSP_OK; wr_en = 1'b1;
    end else if (pay_q[0] == CMD_RD && len_q == 8'd2) begin
      rp[0] = RSP_OK; rp[4:1] = rd_data; rp_n = 3'd5;
    end
    c = '0;
    for (int i = 0; i < 5; i++) if (3'(i) < rp_n) c = crc8(c, rp[i]);
    fr_d[0] = SYNC;
    fr_d[1] = {5'd0, rp_n};
    for (int i = 0; i < 5; i++) fr_d[i+2] = rp[i];
    fr_d[rp_n + 3'd2] = c;
    fr_n = {1'b0, rp_n} + 4'd3;
  end

  // Packet datapath, register file and response byte sequencer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_q <= P_IDLE; tmo_q <= '0; len_q <= '0; idx_q <= '0; crc_q <= '0;
      crc_ok_q <= 1'b0; pay_q <= '0; reg0_q <= '0; loop_q <= '0;
      txa_q <= 1'b0; txb_q <= '0; tlen_q <= '0; tidx_q <= '0;
      tx_wr_q <= 1'b0; tx_byte_q <= '0;
    end else begin
      ps_q    <= ps_d;
      tmo_q   <= (ps_q != P_IDLE && !rx_done) ? tmo_q + 17'd1 : 17'd0;
      tx_wr_q <= 1'b0;
      case (ps_q)
        P_LEN: if (rx_done) begin len_q <= rx_data; idx_q <= '0; crc_q <= '0; end
        P_PAY: if (rx_done) begin
          if (idx_q < 8'd6) pay_q[idx_q[2:0]] <= rx_data;
          crc_q <= crc8(crc_q, rx_data);
          idx_q <= idx_q + 8'd1;
        end
        P_CRC: if (rx_done) crc_ok_q <= (rx_data == crc_q);
        default: ;
      endcase
      if (exec) begin
        if (wr_en && pay_q[1] == 8'd0)      reg0_q <= pay_q[5:2];
        if (wr_en && pay_q[1] == LOOP_ADDR) loop_q <= pay_q[5:2];
        txa_q <= 1'b1; txb_q <= fr_d; tlen_q <= fr_n; tidx_q <= '0;
        tx_wr_q <= 1'b1; tx_byte_q <= fr_d[0];
      end else if (txa_q && tx_done) begin
        if ({1'b0, tidx_q} + 4'd1 == tlen_q) txa_q <= 1'b0;
        else begin
          tidx_q <= tidx_q + 3'd1; tx_byte_q <= txb_q[tidx_q + 3'd1]; tx_wr_q <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_s3g_uart_top.sv
// Directed plus randomized packet tests for the S3G UART bridge at 1 Mbaud.
module tb_s3g_uart_top;
  localparam int BIT = 50;

  logic clk = 1'b0, rst_n = 1'b1, cclk = 1'b0, avr_tx = 1'b1;
  logic avr_rx;
  logic [7:0] led;
  int ncmp = 0, nfail = 0, cyc = 0, last_cyc = 0;
  logic [7:0] rxq[$];
  logic [31:0] m_reg0 = 0, m_loop = 0;

  s3g_uart_top #(.CLK_FREQ(50_000_000), .AVR_BAUD_RATE(1_000_000),
                 .EXT_BAUD_RATE(115200), .CCLK_READY_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .cclk(cclk), .avr_tx(avr_tx), .avr_rx(avr_rx), .led(led));

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bench-side UART receiver capturing bytes sent by the DUT.
  always begin
    logic [7:0] b;
    @(negedge avr_rx);
    repeat (BIT/2) @(negedge clk);
    if (avr_rx == 1'b0) begin
      for (int i = 0; i < 8; i++) begin repeat (BIT) @(negedge clk); b[i] = avr_rx; end
      repeat (BIT) @(negedge clk);
      if (avr_rx == 1'b1) begin rxq.push_back(b); last_cyc = cyc; end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] crcq(input logic [7:0] q[$]);
    logic [7:0] c = 8'h00;
    foreach (q[i]) for (int b = 0; b < 8; b++)
      c = (c[0] ^ q[i][b]) ? ((c >> 1) ^ 8'h8C) : (c >> 1);
    return c;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    avr_tx = 1'b0; repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin avr_tx = b[i]; repeat (BIT) @(negedge clk); end
    avr_tx = 1'b1; repeat (BIT) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] p[$], input logic [7:0] crc_xor);
    send_byte(8'hD5);
    send_byte(8'(p.size()));
    foreach (p[i]) send_byte(p[i]);
    send_byte(crcq(p) ^ crc_xor);
  endtask

  // Reference behaviour: command rules applied to the bench's register copy.
  task automatic model(input logic [7:0] p[$], input bit bad, output logic [7:0] fr[$]);
    logic [7:0] r[$];
    logic [31:0] d;
    if (bad) r.push_back(8'h83);
    else if (p[0] == 8'h00) begin r.push_back(8'h81); r.push_back(8'hBA); r.push_back(8'hCE); end
    else if (p[0] == 8'h3C && p.size() == 6) begin
      d = {p[5], p[4], p[3], p[2]};
      if (p[1] == 8'd0) m_reg0 = d;
      else if (p[1] == 8'd63) m_loop = d;
      r.push_back(8'h81);
    end else if (p[0] == 8'h3D && p.size() == 2) begin
      d = (p[1] == 8'd63) ? m_loop : 32'd0;
      r.push_back(8'h81);
      for (int i = 0; i < 4; i++) r.push_back(d[8*i +: 8]);
    end else r.push_back(8'h85);
    fr = {};
    fr.push_back(8'hD5); fr.push_back(8'(r.size()));
    foreach (r[i]) fr.push_back(r[i]);
    fr.push_back(crcq(r));
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] e[$]);
    int t = 0;
    while (rxq.size() < e.size() && t < 6000) begin @(negedge clk); t++; end
    chk({tag, "_len"}, rxq.size(), e.size());
    foreach (e[i]) chk($sformatf("%s_b%0d", tag, i), (i < rxq.size()) ? rxq[i] : 8'hxx, e[i]);
    rxq.delete();
  endtask

  initial begin
    logic [7:0] p[$], e[$], m[$];
    int t0, t;
    bit low, bad;
    #3 rst_n = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_avr_rx", avr_rx, 1'b1);
    chk("rst_led", led, 8'h00);
    rst_n = 1'b1; cclk = 1'b1;
    repeat (40) @(negedge clk);

    p = {8'h00}; model(p, 0, m); send_frame(p, 8'h00);
    e = {8'hD5, 8'h03, 8'h81, 8'hBA, 8'hCE, 8'hF9}; expect_frame("ver", e);

    p = {8'h12, 8'h13, 8'h14, 8'h15, 8'h16}; model(p, 0, m); send_frame(p, 8'h00);
    e = {8'hD5, 8'h01, 8'h85, 8'hB3}; expect_frame("unk", e);

    p = {8'h3C, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78}; model(p, 0, m); send_frame(p, 8'h00);
    e = {8'hD5, 8'h01, 8'h81, 8'hD2}; expect_frame("wr0", e);
    chk("led_wr0", led, 8'h12);

    p = {8'h3C, 8'h3F, 8'h13, 8'h57, 8'h9B, 8'hDF}; model(p, 0, m); send_frame(p, 8'h00);
    e = {8'hD5, 8'h01, 8'h81, 8'hD2}; expect_frame("wr63", e);

    p = {8'h3D, 8'h3F}; model(p, 0, m); send_frame(p, 8'h00);
    t0 = cyc;
    e = {8'hD5, 8'h05, 8'h81, 8'h13, 8'h57, 8'h9B, 8'hDF, 8'h41}; expect_frame("rd63", e);
    chk("rd63_latency_ok", (last_cyc - t0) <= 4100, 1'b1);

    p = {8'h00}; model(p, 1, m); send_frame(p, 8'h5A);
    expect_frame("badcrc", m);
    chk("led_after_bad", led, m_reg0[7:0]);

    // Link not ready: nothing may come back.
    cclk = 1'b0;
    p = {8'h00}; send_frame(p, 8'h00);
    low = 0;
    for (int i = 0; i < 1500; i++) begin @(negedge clk); if (avr_rx == 1'b0) low = 1; end
    chk("cclk_low_quiet", low, 1'b0);
    chk("cclk_low_rxq", rxq.size(), 0);
    cclk = 1'b1; repeat (40) @(negedge clk);

    // Reset while a response is on the line.
    p = {8'h00}; send_frame(p, 8'h00);
    t = 0;
    while (avr_rx !== 1'b0 && t < 3000) begin @(negedge clk); t++; end
    chk("resp_started", t < 3000, 1'b1);
    repeat (700) @(negedge clk);
    rst_n = 1'b0; m_reg0 = 0; m_loop = 0;
    repeat (2) @(negedge clk);
    chk("rst_mid_tx_line", avr_rx, 1'b1);
    chk("rst_mid_tx_led", led, 8'h00);
    rst_n = 1'b1;
    repeat (1200) @(negedge clk);
    rxq.delete();

    // Reset in the middle of an incoming packet, then a clean packet.
    send_byte(8'hD5); send_byte(8'h06); send_byte(8'h3C); send_byte(8'h00);
    rst_n = 1'b0; repeat (3) @(negedge clk); rst_n = 1'b1;
    repeat (40) @(negedge clk);
    p = {8'h00}; model(p, 0, m); send_frame(p, 8'h00);
    expect_frame("recover", m);

    // Randomized transactions against the reference model.
    for (int n = 0; n < 3; n++) begin
      p = {};
      case ($urandom_range(0, 2))
        0: begin
          p.push_back(8'h3C);
          case ($urandom_range(0, 2))
            0: p.push_back(8'd0);
            1: p.push_back(8'd63);
            default: p.push_back(8'($urandom_range(1, 62)));
          endcase
          for (int i = 0; i < 4; i++) p.push_back(8'($urandom_range(0, 255)));
        end
        1: begin
          p.push_back(8'h3D);
          p.push_back($urandom_range(0, 1) ? 8'd63 : 8'($urandom_range(0, 62)));
        end
        default: begin
          p.push_back($urandom_range(0, 1) ? 8'h3C : 8'h3D);
          for (int i = 0; i < 3; i++) p.push_back(8'($urandom_range(0, 255)));
        end
      endcase
      bad = ($urandom_range(0, 3) == 0);
      model(p, bad, m);
      send_frame(p, bad ? 8'(1 << $urandom_range(0, 7)) : 8'h00);
      expect_frame($sformatf("rnd%0d", n), m);
      chk($sformatf("rnd%0d_led", n), led, m_reg0[7:0]);
    end

    p = {8'h3D, 8'h3F}; model(p, 0, m); send_frame(p, 8'h00);
    expect_frame("rd_final", m);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/s3g_uart_top.md
# s3g_uart_top

FPGA top level that bridges the AVR serial link to a small register file using S3G-style framed packets. It includes a DDS baud generator and an 8N1 UART transceiver. It parses incoming packets, checks the CRC, executes version, register-write and register-read commands, and returns a framed response. It drives the board LEDs from register 0 and provides a loop-back register for link testing.

## Interface
Parameters:
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- AVR_BAUD_RATE, 115200: AVR link bit rate.
- EXT_BAUD_RATE, 115200: reserved for an external port; accepted and unused.
- CCLK_READY_CYCLES, 512: number of consecutive cycles with cclk high before the link is enabled.

Ports:
- clk, input, 1: system clock. One clock domain only.
- rst_n, input, 1: reset. Asynchronous and active-low.
- cclk, input, 1: AVR configuration clock. High means the AVR is ready.
- avr_tx, input, 1: serial data from the AVR.
- avr_rx, output, 1: serial data to the AVR. Reset value 1 (idle).
- led, output, 8: equals reg0[7:0]. Reset value 0.

## Operation
Link enable:
- Counter of consecutive cycles with cclk=1; cleared whenever cclk=0.
- Link is ready once the counter reaches CCLK_READY_CYCLES.
- Until ready: receiver ignored, avr_rx held at 1.

Baud generator:
- 32-bit phase accumulator. Increment = round(16·BAUD·2^32/CLK_FREQ).
- Carry-out gives a one-cycle enable_16 pulse at 16× baud.

UART:
- 8N1, LSB first, 16× oversampling.
- RX: start bit validated at mid-bit; each bit sampled at mid-bit. rx_done pulses one cycle with the byte at the stop-bit sample.
- RX: a framing error (stop bit = 0) discards the byte.
- TX: tx_wr loads a byte; tx_done pulses one cycle after the stop bit.

Packet format: 0xD5, LEN, payload[LEN], CRC.
- CRC is the Dallas/Maxim CRC-8 over the payload only: init 0x00; per bit, `crc = (crc^bit)&1 ? (crc>>1)^0x8C : crc>>1`, LSB first.
- RX FSM: IDLE (wait 0xD5, other bytes dropped) → LEN → PAYLOAD → CRC → EXEC.
- LEN=0 or LEN>32: drop the packet and return to IDLE.
- No byte for 100_000 cycles in any non-IDLE state: return to IDLE.

Commands (payload[0]):
- 0x00 version: reply 0x81, 0xBA, 0xCE.
- 0x3C write register: LEN must be 6. payload[1]=address, payload[2..5]=little-endian 32-bit data. Reply 0x81.
  - Address 0: reg0; led = reg0[7:0].
  - Address 63: loop-back register.
  - Other addresses: accepted, no effect.
- 0x3D read input: LEN must be 2. payload[1]=address. Reply 0x81 followed by the 4 data bytes, little-endian.
  - Address 63 returns the loop-back register; all other addresses return 0.
- Bad CRC: reply 0x83.
- Unknown command or wrong LEN: reply 0x85.

Response frame: 0xD5, LEN, payload, CRC, with the CRC computed the same way.

Packet completed while a response is still transmitting: drop the new packet.

## Timing
- First response byte is written ≤8 cycles after the rx_done of the request's CRC byte.
- Response bytes are back-to-back: each next tx_wr ≤2 cycles after tx_done.
- Register writes take effect in the EXEC cycle, before the response starts.
- Reset values: reg0 = 0, loop-back = 0, led = 0, avr_rx = 1, all FSMs in IDLE, cclk counter = 0.
- Reset mid-frame aborts immediately; the line returns to idle.

## Structure
- Shared package: constants SYNC=0xD5, MAX_LEN=32, codes 0x81/0x83/0x85, commands 0x00/0x3C/0x3D, version bytes 0xBA/0xCE, CRC poly 0x8C, timeout value.
- Sub-module: s3g_uart_phy, containing the DDS enable generator plus the UART RX/TX.
- Packet RX/TX FSMs, CRC, and the register file live in the top.

## Test plan
- AVR_BAUD_RATE=1_000_000, cclk high before traffic:
  - Send D5 01 00 00 → receive D5 03 81 BA CE F9.
- Send D5 05 12 13 14 15 16 + CRC → receive D5 01 85 B3.
- Send D5 06 3C 00 12 34 56 78 + CRC → receive D5 01 81 D2; led = 0x12.
- Send D5 06 3C 3F 13 57 9B DF + CRC → receive D5 01 81 D2; loop-back = 0xDF9B5713.
- Send D5 02 3D 3F + CRC → receive D5 05 81 13 57 9B DF 41, with the whole frame finished within 4100 cycles of the last request byte.
- Send a corrupted CRC → receive D5 01 83 + CRC.
- Hold cclk low → no response.
- Assert rst_n low mid-packet → clean recovery on the next packet.
